// File: rtl/div_result_bcd.sv
// div_result_bcd: sequential binary-to-BCD converter for the divider_8bit
// quotient and remainder. Both operands are converted in parallel with
// shift-and-add-3 over Q_W shift cycles; results go to the 7-segment driver.
// Optional build macro: DIV_BCD_LEADING_BLANK_EN replaces leading zero
// digits with 4'hF (blank) when a conversion completes.
module div_result_bcd #(
    parameter int Q_W = 8,
    parameter int R_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [Q_W-1:0] q,
    input  logic [R_W-1:0] r,
    output logic           busy,
    output logic           done,
    output logic [3:0]     q_hund,
    output logic [3:0]     q_tens,
    output logic [3:0]     q_ones,
    output logic [3:0]     r_tens,
    output logic [3:0]     r_ones
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_next;

    // cnt is one bit wider than needed so an out-of-range value is detectable
    logic [3:0]     cnt;
    logic [Q_W-1:0] qsh;
    logic [Q_W-1:0] rsh;
    logic [11:0]    qb;
    logic [7:0]     rb;
    logic [11:0]    qb_adj;
    logic [7:0]     rb_adj;
    logic [11:0]    qb_shift;
    logic [7:0]     rb_shift;
    logic           last_shift;
    logic           cnt_bad;

    assign busy    = (state == SHIFT);
    assign cnt_bad = (cnt > 4'd7);

    // Add-3 correction of every BCD nibble that is 5 or more, then the shift
    always_comb begin
        qb_adj = qb;
        rb_adj = rb;
        for (int i = 0; i < 3; i++) begin
            if (qb[4*i +: 4] >= 4'd5) begin
                qb_adj[4*i +: 4] = qb[4*i +: 4] + 4'd3;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (rb[4*i +: 4] >= 4'd5) begin
                rb_adj[4*i +: 4] = rb[4*i +: 4] + 4'd3;
            end
        end
        qb_shift = {qb_adj[10:0], qsh[Q_W-1]};
        rb_shift = {rb_adj[6:0], rsh[Q_W-1]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; last_shift marks the edge that completes the 8th shift
    always_comb begin
        state_next = state;
        last_shift = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_bad) begin
                    state_next = IDLE;
                end else if (cnt == 4'd7) begin
                    last_shift = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, shift datapath and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
            qsh <= '0;
            rsh <= '0;
            qb  <= 12'd0;
            rb  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        qsh <= q;
                        rsh <= Q_W'(r);
                        qb  <= 12'd0;
                        rb  <= 8'd0;
                        cnt <= 4'd0;
                    end
                end
                SHIFT: begin
                    if (cnt_bad) begin
                        cnt <= 4'd0;
                    end else begin
                        qb  <= qb_shift;
                        rb  <= rb_shift;
                        qsh <= qsh << 1;
                        rsh <= rsh << 1;
                        cnt <= last_shift ? 4'd0 : cnt + 4'd1;
                    end
                end
                default: cnt <= 4'd0;
            endcase
        end
    end

    // Output digit registers, loaded only on completion, plus the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            q_hund <= 4'h0;
            q_tens <= 4'h0;
            q_ones <= 4'h0;
            r_tens <= 4'h0;
            r_ones <= 4'h0;
        end else begin
            done <= last_shift;
            if (last_shift) begin
`ifdef DIV_BCD_LEADING_BLANK_EN
                q_hund <= (qb_shift[11:8] == 4'h0) ? 4'hF : qb_shift[11:8];
                q_tens <= (qb_shift[11:4] == 8'h00) ? 4'hF : qb_shift[7:4];
                r_tens <= (rb_shift[7:4] == 4'h0) ? 4'hF : rb_shift[7:4];
`else
                q_hund <= qb_shift[11:8];
                q_tens <= qb_shift[7:4];
                r_tens <= rb_shift[7:4];
`endif
                q_ones <= qb_shift[3:0];
                r_ones <= rb_shift[3:0];
            end
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: directed self-checking bench for div_result_bcd with an
// arithmetic reference model compared on every cycle out of reset.
module tb_div_result_bcd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] q = 8'd0;
    logic [4:0] r = 5'd0;
    logic       busy, done;
    logic [3:0] q_hund, q_tens, q_ones, r_tens, r_ones;

    int total = 0;
    int bad = 0;

    div_result_bcd dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .q      (q),
        .r      (r),
        .busy   (busy),
        .done   (done),
        .q_hund (q_hund),
        .q_tens (q_tens),
        .q_ones (q_ones),
        .r_tens (r_tens),
        .r_ones (r_ones)
    );

    always #5 clk = ~clk;

    // Expected digits from plain decimal arithmetic
    function automatic logic [19:0] calcDigits(input int qv, input int rv);
        int qh, qt, qo, rt, ro;
        qh = qv / 100;
        qt = (qv / 10) % 10;
        qo = qv % 10;
        rt = rv / 10;
        ro = rv % 10;
`ifdef DIV_BCD_LEADING_BLANK_EN
        if (qv < 100) qh = 15;
        if (qv < 10) qt = 15;
        if (rv < 10) rt = 15;
`endif
        return {qh[3:0], qt[3:0], qo[3:0], rt[3:0], ro[3:0]};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion takes 8 edges after acceptance
    int         remain = 0;
    logic       mDone = 1'b0;
    logic [19:0] mDigits = 20'h0;
    logic [19:0] pending = 20'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain  = 0;
            mDone   = 1'b0;
            mDigits = 20'h0;
        end else begin
            mDone = 1'b0;
            if (remain != 0) begin
                remain--;
                if (remain == 0) begin
                    mDone   = 1'b1;
                    mDigits = pending;
                end
            end else if (start) begin
                pending = calcDigits(int'(q), int'(r));
                remain  = 8;
            end
        end
    end

    // Compare DUT against the model every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            checkVal("busy", 32'(busy), 32'(remain != 0));
            checkVal("done", 32'(done), 32'(mDone));
            checkVal("digits", 32'({q_hund, q_tens, q_ones, r_tens, r_ones}), 32'(mDigits));
        end
    end

    task automatic applyStimulus(input logic [7:0] qv, input logic [4:0] rv);
        @(negedge clk);
        start = 1'b1;
        q = qv;
        r = rv;
        @(negedge clk);
        start = 1'b0;
        q = ~qv;
        r = ~rv;
    endtask

    task automatic waitDone(output int cycles, output int busyCnt);
        cycles = 0;
        busyCnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busyCnt++;
            @(negedge clk);
            cycles++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("[TB] FAIL done_timeout: got done=0 expected done=1 within 20 cycles");
        end
    endtask

    task automatic checkOutput(input string name, input logic [19:0] expDef, input logic [19:0] expBlank);
`ifdef DIV_BCD_LEADING_BLANK_EN
        checkVal(name, 32'({q_hund, q_tens, q_ones, r_tens, r_ones}), 32'(expBlank));
`else
        checkVal(name, 32'({q_hund, q_tens, q_ones, r_tens, r_ones}), 32'(expDef));
`endif
    endtask

    initial begin
        int cyc, bcnt, doneCnt;
        repeat (2) @(negedge clk);
        checkVal("reset_busy", 32'(busy), 32'd0);
        checkVal("reset_done", 32'(done), 32'd0);
        checkOutput("reset_digits", 20'h00000, 20'h00000);
        #1 rst_n = 1'b1;

        applyStimulus(8'd10, 5'd5);
        waitDone(cyc, bcnt);
        checkOutput("q10_r5", 20'h01005, 20'hF10F5);
        checkVal("q10_latency", 32'(cyc), 32'd8);

        applyStimulus(8'd255, 5'd31);
        waitDone(cyc, bcnt);
        checkOutput("q255_r31", 20'h25531, 20'h25531);
        checkVal("busy_cycles", 32'(bcnt), 32'd8);
        @(negedge clk);
        checkVal("done_one_cycle", 32'(done), 32'd0);

        applyStimulus(8'd0, 5'd0);
        waitDone(cyc, bcnt);
        checkOutput("q0_r0", 20'h00000, 20'hFF0F0);

        applyStimulus(8'd5, 5'd0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        q = 8'd99;
        r = 5'd4;
        @(negedge clk);
        start = 1'b0;
        waitDone(cyc, bcnt);
        checkOutput("start_ignored", 20'h00500, 20'hFF5F0);

        applyStimulus(8'd63, 5'd2);
        waitDone(cyc, bcnt);
        checkOutput("q63_r2", 20'h06302, 20'hF63F2);
        start = 1'b1;
        q = 8'd200;
        r = 5'd17;
        @(negedge clk);
        start = 1'b0;
        waitDone(cyc, bcnt);
        checkOutput("back_to_back", 20'h20017, 20'h20017);
        checkVal("back_to_back_gap", 32'(cyc), 32'd8);

        start = 1'b1;
        q = 8'd7;
        r = 5'd3;
        doneCnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        start = 1'b0;
        checkVal("held_start_dones", 32'(doneCnt), 32'd2);
        checkOutput("held_start_digits", 20'h00703, 20'hFF7F3);
        repeat (10) @(negedge clk);

        applyStimulus(8'd128, 5'd9);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkVal("midreset_busy", 32'(busy), 32'd0);
        checkVal("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_digits", 20'h00000, 20'h00000);
        @(negedge clk);
        #1 rst_n = 1'b1;
        doneCnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkVal("no_done_after_reset", 32'(doneCnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
